// File: rtl/dm_bus_arbiter_pkg.sv
// Shared definitions for the data-side bus arbiter: FSM states, owner IDs
// and default timing parameters.
package dm_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  localparam int DEFAULT_TIMEOUT = 16;
  localparam int DEFAULT_CNT_W   = 8;

endpackage

// File: rtl/dm_bus_arbiter_bus_timeout_counter.sv
// Counts BUS-state cycles of the current transaction; expired is high on the
// last cycle a transaction is allowed to wait for BusReady.
module bus_timeout_counter #(
  parameter int CNT_W = 8,
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign expired = (count_q == LAST);

endmodule

// File: rtl/dm_bus_arbiter.sv
// Arbitrates the data-side device bus between the CPU MEM stage and the
// DMA/debug port, running one timed bus transaction per grant.
module dm_bus_arbiter
  import dm_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = DEFAULT_CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CpuReq,
  input  logic        CpuWe,
  input  logic [31:0] CpuAddr,
  input  logic [31:0] CpuWData,
  input  logic [3:0]  CpuByteEn,
  input  logic        CpuExc,
  output logic        CpuAck,
  output logic [31:0] CpuRData,
  output logic        CpuErr,
  output logic        CpuStall,
  input  logic        DmaReq,
  input  logic        DmaWe,
  input  logic [31:0] DmaAddr,
  input  logic [31:0] DmaWData,
  input  logic [3:0]  DmaByteEn,
  output logic        DmaAck,
  output logic [31:0] DmaRData,
  output logic        DmaErr,
  output logic        BusReq,
  output logic        BusWe,
  output logic [31:0] BusAddr,
  output logic [31:0] BusWData,
  output logic [3:0]  BusByteEn,
  input  logic        BusReady,
  input  logic [31:0] BusRData
);

  // Handshake: a requester holds Req and its fields stable until it sees a
  // one-cycle Ack, and drops Req on that same edge. The bus side holds BusReq
  // and the registered fields until a cycle with BusReady completes the beat.

  state_t      state_q, state_d;
  owner_t      owner_q, last_grant_q, grant_owner;
  logic        grant, exc_hit, bus_done, bus_abort;
  logic        expired, cnt_enable;
  logic        bus_we_q;
  logic [31:0] bus_addr_q, bus_wdata_q;
  logic [3:0]  bus_byte_en_q;
  logic [31:0] cpu_rdata_q, dma_rdata_q;
  logic        cpu_err_q, dma_err_q;
  logic [31:0] resp_rdata;
  logic        resp_err;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant       = 1'b0;
    grant_owner = OWN_CPU;
    exc_hit     = 1'b0;
    bus_done    = 1'b0;
    bus_abort   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A pre-flagged CPU access never touches the bus and beats DMA.
        if (CpuReq && CpuExc) begin
          exc_hit = 1'b1;
          state_d = ST_RESP;
        end else if (CpuReq || DmaReq) begin
          grant   = 1'b1;
          state_d = ST_BUS;
          if (CpuReq && DmaReq) begin
            grant_owner = (last_grant_q == OWN_DMA) ? OWN_CPU : OWN_DMA;
          end else begin
            grant_owner = CpuReq ? OWN_CPU : OWN_DMA;
          end
        end
      end
      ST_BUS: begin
        // Ready on the final allowed cycle still counts as success.
        if (BusReady) begin
          bus_done = 1'b1;
          state_d  = ST_RESP;
        end else if (expired) begin
          bus_abort = 1'b1;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign resp_rdata = (bus_done && !bus_we_q) ? BusRData : 32'h0;
  assign resp_err   = bus_abort;

  always_ff @(posedge clk) begin
    if (!reset) begin
      owner_q       <= OWN_CPU;
      last_grant_q  <= OWN_DMA;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= '0;
      bus_wdata_q   <= '0;
      bus_byte_en_q <= '0;
      cpu_rdata_q   <= '0;
      cpu_err_q     <= 1'b0;
      dma_rdata_q   <= '0;
      dma_err_q     <= 1'b0;
    end else begin
      if (exc_hit) begin
        owner_q     <= OWN_CPU;
        cpu_rdata_q <= '0;
        cpu_err_q   <= 1'b1;
      end
      if (grant) begin
        owner_q      <= grant_owner;
        last_grant_q <= grant_owner;
        if (grant_owner == OWN_CPU) begin
          bus_we_q      <= CpuWe;
          bus_addr_q    <= CpuAddr;
          bus_wdata_q   <= CpuWData;
          bus_byte_en_q <= CpuByteEn;
        end else begin
          bus_we_q      <= DmaWe;
          bus_addr_q    <= DmaAddr;
          bus_wdata_q   <= DmaWData;
          bus_byte_en_q <= DmaByteEn;
        end
      end
      // Per-port result registers double as the hold-until-next-Ack storage.
      if (bus_done || bus_abort) begin
        if (owner_q == OWN_CPU) begin
          cpu_rdata_q <= resp_rdata;
          cpu_err_q   <= resp_err;
        end else begin
          dma_rdata_q <= resp_rdata;
          dma_err_q   <= resp_err;
        end
      end
    end
  end

  assign cnt_enable = (state_q == ST_BUS) && !BusReady && !expired;

  bus_timeout_counter #(
    .CNT_W (CNT_W),
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (grant),
    .enable  (cnt_enable),
    .expired (expired)
  );

  assign CpuAck    = (state_q == ST_RESP) && (owner_q == OWN_CPU);
  assign DmaAck    = (state_q == ST_RESP) && (owner_q == OWN_DMA);
  assign CpuRData  = cpu_rdata_q;
  assign CpuErr    = cpu_err_q;
  assign DmaRData  = dma_rdata_q;
  assign DmaErr    = dma_err_q;
  assign CpuStall  = CpuReq & ~CpuAck;
  assign BusReq    = (state_q == ST_BUS);
  assign BusWe     = BusReq & bus_we_q;
  assign BusAddr   = bus_addr_q;
  assign BusWData  = bus_wdata_q;
  assign BusByteEn = bus_byte_en_q;

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// Directed bench for dm_bus_arbiter: latency, exception bypass, alternation,
// timeout boundary, reset mid-transaction and wait-state stability.
module tb_dm_bus_arbiter;
  import dm_bus_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        CpuReq, CpuWe, CpuExc;
  logic [31:0] CpuAddr, CpuWData;
  logic [3:0]  CpuByteEn;
  logic        CpuAck, CpuErr, CpuStall;
  logic [31:0] CpuRData;
  logic        DmaReq, DmaWe;
  logic [31:0] DmaAddr, DmaWData;
  logic [3:0]  DmaByteEn;
  logic        DmaAck, DmaErr;
  logic [31:0] DmaRData;
  logic        BusReq, BusWe, BusReady;
  logic [31:0] BusAddr, BusWData, BusRData;
  logic [3:0]  BusByteEn;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dm_bus_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .CpuReq    (CpuReq),
    .CpuWe     (CpuWe),
    .CpuAddr   (CpuAddr),
    .CpuWData  (CpuWData),
    .CpuByteEn (CpuByteEn),
    .CpuExc    (CpuExc),
    .CpuAck    (CpuAck),
    .CpuRData  (CpuRData),
    .CpuErr    (CpuErr),
    .CpuStall  (CpuStall),
    .DmaReq    (DmaReq),
    .DmaWe     (DmaWe),
    .DmaAddr   (DmaAddr),
    .DmaWData  (DmaWData),
    .DmaByteEn (DmaByteEn),
    .DmaAck    (DmaAck),
    .DmaRData  (DmaRData),
    .DmaErr    (DmaErr),
    .BusReq    (BusReq),
    .BusWe     (BusWe),
    .BusAddr   (BusAddr),
    .BusWData  (BusWData),
    .BusByteEn (BusByteEn),
    .BusReady  (BusReady),
    .BusRData  (BusRData)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    CpuReq = 0; CpuWe = 0; CpuExc = 0; CpuAddr = 0; CpuWData = 0; CpuByteEn = 0;
    DmaReq = 0; DmaWe = 0; DmaAddr = 0; DmaWData = 0; DmaByteEn = 0;
    BusReady = 0; BusRData = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // Reset state
    do_reset();
    check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    check("rst_cpu_ack", 32'(CpuAck), 32'd0);
    check("rst_dma_ack", 32'(DmaAck), 32'd0);
    check("rst_bus_req", 32'(BusReq), 32'd0);
    check("rst_bus_addr", BusAddr, 32'h0);
    check("rst_cpu_rdata", CpuRData, 32'h0);

    // CPU load, zero-wait device
    CpuReq = 1; CpuWe = 0; CpuAddr = 32'h0000_0010; CpuByteEn = 4'hF;
    BusReady = 1; BusRData = 32'hDEAD_BEEF;
    #1;
    check("ld_stall", 32'(CpuStall), 32'd1);
    tick();
    check("ld_busreq_c1", 32'(BusReq), 32'd1);
    check("ld_busaddr", BusAddr, 32'h0000_0010);
    check("ld_buswe", 32'(BusWe), 32'd0);
    check("ld_ack_c1", 32'(CpuAck), 32'd0);
    tick();
    check("ld_busreq_c2", 32'(BusReq), 32'd0);
    check("ld_ack_c2", 32'(CpuAck), 32'd1);
    check("ld_rdata", CpuRData, 32'hDEAD_BEEF);
    check("ld_err", 32'(CpuErr), 32'd0);
    check("ld_stall_ack", 32'(CpuStall), 32'd0);
    check("ld_dma_ack", 32'(DmaAck), 32'd0);
    CpuReq = 0;
    tick();
    check("ld_ack_drop", 32'(CpuAck), 32'd0);
    check("ld_rdata_hold", CpuRData, 32'hDEAD_BEEF);

    // CPU store flagged with an address exception never reaches the bus
    CpuReq = 1; CpuWe = 1; CpuExc = 1; CpuAddr = 32'h0000_0003; CpuWData = 32'h1111_2222;
    tick();
    check("exc_ack", 32'(CpuAck), 32'd1);
    check("exc_err", 32'(CpuErr), 32'd1);
    check("exc_busreq", 32'(BusReq), 32'd0);
    CpuReq = 0; CpuExc = 0;
    tick();
    check("exc_ack_drop", 32'(CpuAck), 32'd0);
    check("exc_busreq2", 32'(BusReq), 32'd0);

    // Continuous contention from reset alternates CPU, DMA, CPU, DMA
    do_reset();
    CpuReq = 1; CpuWe = 0; CpuAddr = 32'h0000_0010; CpuByteEn = 4'hF;
    DmaReq = 1; DmaWe = 0; DmaAddr = 32'h0000_0020; DmaByteEn = 4'hF;
    BusReady = 1;
    for (int i = 0; i < 4; i++) begin
      logic exp_cpu;
      exp_cpu  = (i % 2 == 0);
      BusRData = 32'hA000_0000 + 32'(i);
      tick();
      check($sformatf("arb%0d_addr", i), BusAddr, exp_cpu ? 32'h10 : 32'h20);
      tick();
      check($sformatf("arb%0d_cpu_ack", i), 32'(CpuAck), 32'(exp_cpu));
      check($sformatf("arb%0d_dma_ack", i), 32'(DmaAck), 32'(!exp_cpu));
      check($sformatf("arb%0d_rdata", i), exp_cpu ? CpuRData : DmaRData, 32'hA000_0000 + 32'(i));
      tick();
      check($sformatf("arb%0d_acks_low", i), 32'({CpuAck, DmaAck}), 32'd0);
    end
    CpuReq = 0; DmaReq = 0;

    // DMA load with a device that never answers: 16 BUS cycles then error
    DmaReq = 1; DmaWe = 0; DmaAddr = 32'h0000_0040;
    BusReady = 0; BusRData = 32'h1234_5678;
    tick();
    n = 0;
    for (int k = 0; k < 40 && BusReq; k++) begin
      n++;
      tick();
    end
    check("to_bus_cycles", 32'(n), 32'd16);
    check("to_ack", 32'(DmaAck), 32'd1);
    check("to_err", 32'(DmaErr), 32'd1);
    check("to_rdata", DmaRData, 32'h0);
    DmaReq = 0;
    tick();

    // Ready arriving exactly on the 16th BUS cycle is a success
    DmaReq = 1;
    tick();
    repeat (15) tick();
    check("edge_busreq_c16", 32'(BusReq), 32'd1);
    BusReady = 1; BusRData = 32'hCAFE_F00D;
    tick();
    check("edge_ack", 32'(DmaAck), 32'd1);
    check("edge_err", 32'(DmaErr), 32'd0);
    check("edge_rdata", DmaRData, 32'hCAFE_F00D);
    DmaReq = 0; BusReady = 0;
    tick();

    // Reset on the 3rd BUS cycle of a CPU load abandons it
    CpuReq = 1; CpuWe = 0; CpuAddr = 32'h0000_0050; CpuByteEn = 4'hF;
    tick();
    tick();
    tick();
    check("rbus_busreq_c3", 32'(BusReq), 32'd1);
    reset = 1'b0;
    tick();
    check("rbus_busreq", 32'(BusReq), 32'd0);
    check("rbus_state", 32'(dut.state_q), 32'(ST_IDLE));
    check("rbus_ack", 32'(CpuAck), 32'd0);
    reset = 1'b1;
    DmaReq = 1; DmaAddr = 32'h0000_0060;
    BusReady = 1; BusRData = 32'h5555_5555;
    tick();
    check("rbus_regrant_addr", BusAddr, 32'h0000_0050);
    check("rbus_regrant_ack0", 32'(CpuAck), 32'd0);
    tick();
    check("rbus_cpu_ack", 32'(CpuAck), 32'd1);
    check("rbus_dma_ack", 32'(DmaAck), 32'd0);
    check("rbus_rdata", CpuRData, 32'h5555_5555);
    CpuReq = 0; DmaReq = 0;
    tick();

    // TC0 store with 3 device wait cycles; bus fields must hold
    CpuReq = 1; CpuWe = 1; CpuAddr = 32'h0000_7F00; CpuWData = 32'h0BAD_F00D; CpuByteEn = 4'hF;
    BusReady = 0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 4) BusReady = 1;
      check($sformatf("st_addr_c%0d", c), BusAddr, 32'h0000_7F00);
      check($sformatf("st_wdata_c%0d", c), BusWData, 32'h0BAD_F00D);
      check($sformatf("st_be_c%0d", c), 32'(BusByteEn), 32'hF);
      check($sformatf("st_we_c%0d", c), 32'(BusWe), 32'd1);
      check($sformatf("st_ack_c%0d", c), 32'(CpuAck), 32'd0);
    end
    tick();
    check("st_ack_c5", 32'(CpuAck), 32'd1);
    check("st_err", 32'(CpuErr), 32'd0);
    check("st_rdata", CpuRData, 32'h0);
    check("st_busreq_c5", 32'(BusReq), 32'd0);
    CpuReq = 0; BusReady = 0;
    tick();
    check("st_ack_drop", 32'(CpuAck), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_bus_arbiter.md
Name: dm_bus_arbiter

Overview:
- Shares the single data-side device bus (DM, TC0, TC1, interrupt-response window) between two requesters: the CPU MEM stage and a DMA/debug port.
- Sequences each access as a multi-cycle bus transaction with a ready handshake and a timeout.
- Short-circuits CPU accesses that the address-exception check has already flagged, so they never reach the bus.
- Sits between the MEM stage / DMA engine and the bridge.

Parameters:
- TIMEOUT, 16, maximum number of BUS-state cycles allowed before a transaction is aborted with error (legal range 2..255).
- CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- CpuReq  in  1  CPU access request; held stable until CpuAck.
- CpuWe  in  1  1 = store, 0 = load.
- CpuAddr  in  32  byte address.
- CpuWData  in  32  store data.
- CpuByteEn  in  4  byte lanes.
- CpuExc  in  1  AdEL/AdES already raised for this access.
- CpuAck  out  1  one-cycle completion pulse.
- CpuRData  out  32  load data, valid with CpuAck.
- CpuErr  out  1  access failed (exception or timeout), valid with CpuAck.
- CpuStall  out  1  equals CpuReq & ~CpuAck; combinational.
- DmaReq  in  1  DMA request; held until DmaAck.
- DmaWe  in  1  1 = store, 0 = load.
- DmaAddr  in  32  byte address.
- DmaWData  in  32  store data.
- DmaByteEn  in  4  byte lanes.
- DmaAck  out  1  one-cycle completion pulse.
- DmaRData  out  32  load data, valid with DmaAck.
- DmaErr  out  1  access failed (timeout), valid with DmaAck.
- BusReq  out  1  transaction active toward the bridge.
- BusWe  out  1  write strobe qualifier.
- BusAddr  out  32  registered address.
- BusWData  out  32  registered store data.
- BusByteEn  out  4  registered byte lanes.
- BusReady  in  1  device completes the current beat.
- BusRData  in  32  device read data, sampled with BusReady.

Behaviour:
- **Reset** (reset==0 at an edge):
  - state=IDLE.
  - All Ack/Err/BusReq/BusWe = 0; RData, BusAddr, BusWData, BusByteEn = 0; counter = 0.
  - LastGrant = DMA, so the CPU wins the first tie.
  - Reset during BUS abandons the transaction: BusReq falls on the next cycle and no Ack is issued.
- **States:** IDLE, BUS, RESP.
- **IDLE:**
  - If CpuReq & CpuExc: Owner=CPU, Err=1, go to RESP with no bus cycle. This takes priority over DMA.
  - Else if exactly one requester is active: grant it.
  - If both are active: grant the one not equal to LastGrant.
  - On grant: register We/Addr/WData/ByteEn of the owner, set Owner, set LastGrant=Owner, clear counter, go to BUS.
  - No request: stay in IDLE.
- **BUS:**
  - BusReq=1 with the registered fields, held constant for the whole state.
  - If BusReady: latch BusRData (load) or 0 (store), Err=0, go to RESP.
  - Else if counter==TIMEOUT-1: Err=1, RData=0, go to RESP.
  - Else increment the counter.
  - BusReady on the same cycle the counter reaches the limit counts as success.
- **RESP:**
  - Owner's Ack=1 for exactly one cycle, with registered RData/Err; the other port's Ack stays 0.
  - Return to IDLE.
  - Requesters drop Req on the edge that sees Ack, so IDLE never re-grants a completed request.
- **Latency:**
  - Exception short-circuit: Ack 1 cycle after request sampled.
  - Zero-wait device: Ack 2 cycles after request sampled.
  - Each device wait cycle adds 1.
- **Fairness:**
  - Strict alternation under continuous contention.
  - A request arriving while the other port is being serviced waits; it is granted in the next IDLE.
- **Data path:**
  - No sub-word manipulation: ByteEn and data pass through unchanged.
  - CpuRData/DmaRData hold their value until the next Ack to the same port.

Decomposition:
- Shared package: state encodings (IDLE/BUS/RESP); owner IDs (CPU=0, DMA=1); default TIMEOUT.
- Address-map bounds stay in the existing bridge constants file.
- One sub-module: bus_timeout_counter (clear, enable, limit compare, expired flag).

Test Plan:
- CPU load to DM address 0x0000_0010, BusReady tied 1, BusRData=0xDEAD_BEEF -> BusReq high exactly 1 cycle; CpuAck 2 cycles after CpuReq with CpuRData=0xDEAD_BEEF, CpuErr=0.
- CPU store with CpuExc=1 -> BusReq never asserts; CpuAck+CpuErr=1 one cycle after request.
- CpuReq and DmaReq asserted together from reset, BusReady=1, both held for 4 transactions -> grant order CPU, DMA, CPU, DMA; no cycle has both Acks.
- DMA access with BusReady held 0, TIMEOUT=16 -> 16 BUS cycles, then DmaAck with DmaErr=1 and DmaRData=0; BusReady asserted exactly on cycle 16 instead -> DmaErr=0.
- Reset asserted on the 3rd BUS cycle of a CPU load -> next cycle BusReq=0, state IDLE, no CpuAck; a re-issued request is granted to the CPU first.
- Device inserting 3 wait cycles on a TC0 store (address 0x7F00, ByteEn=4'hF) -> BusAddr/BusWData/BusByteEn stable for all 4 BUS cycles; CpuAck 5 cycles after request.
